// File: rtl/tx_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tx_burst_ctrl
//  Description : Multi-byte transmit sequencer for the UART byte serializer.
//                Captures a BYTES-wide word on iStart, then runs the
//                serializer's load / transmit / reset handshake once per
//                byte, least-significant byte first, and reports busy/done.
//                Optional feature macro: TX_BURST_GAP_EN adds GAP_CYCLES idle
//                cycles between consecutive bytes (GAP state + 16-bit count).
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_burst_ctrl #(
  parameter int BYTES      = 4,
  parameter int GAP_CYCLES = 16,
  localparam int IW        = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iStart,
  input  logic [8*BYTES-1:0] iData,
  input  logic               iTxDone,
  output logic [7:0]         oByte,
  output logic               oLoad,
  output logic               oTransmit,
  output logic               oTxReset,
  output logic               oBusy,
  output logic               oDone,
  output logic [IW-1:0]      oByteIdx
);

  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  // The GAP code is reserved in both builds; without the gap feature it is
  // simply unreachable and would fall back to IDLE like any unused code.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_TRANSMIT = 3'd2,
    ST_TXRESET  = 3'd3,
    ST_GAP      = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [8*BYTES-1:0]   shadow_q, shadow_d;

`ifdef TX_BURST_GAP_EN
  localparam logic [15:0] GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  logic [15:0]          gap_q, gap_d;
`endif

  // Next-state logic: sequencing of bytes through the serializer handshake.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
`ifdef TX_BURST_GAP_EN
    gap_d    = gap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          shadow_d = iData;
          idx_d    = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD:     state_d = ST_TRANSMIT;
      ST_TRANSMIT: if (iTxDone) state_d = ST_TXRESET;
      ST_TXRESET: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
`ifdef TX_BURST_GAP_EN
          if (GAP_CYCLES > 0) begin
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            state_d = ST_LOAD;
          end
`else
          state_d = ST_LOAD;
`endif
        end
      end
`ifdef TX_BURST_GAP_EN
      ST_GAP: begin
        if (gap_q == 16'd0) state_d = ST_LOAD;
        else                gap_d   = gap_q - 16'd1;
      end
`endif
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered Moore outputs (decoded from the next state
  // so each strobe is aligned with the state it belongs to).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
`ifdef TX_BURST_GAP_EN
      gap_q     <= 16'd0;
`endif
      oLoad     <= 1'b0;
      oTransmit <= 1'b0;
      oTxReset  <= 1'b1;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
`ifdef TX_BURST_GAP_EN
      gap_q     <= gap_d;
`endif
      oLoad     <= (state_d == ST_LOAD);
      oTransmit <= (state_d == ST_TRANSMIT);
      oTxReset  <= (state_d != ST_TXRESET);
      oBusy     <= (state_d != ST_IDLE);
      oDone     <= (state_d == ST_DONE);
    end
  end

  // Byte mux from registered index and shadow: stable for the whole byte.
  assign oByte    = shadow_q[8*idx_q +: 8];
  assign oByteIdx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_burst_ctrl
//  Description : Self-checking bench for tx_burst_ctrl (BYTES=4 and BYTES=1
//                instances) against a word-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_burst_ctrl;

  localparam int NB  = 4;
  localparam int GAP = 5;
`ifdef TX_BURST_GAP_EN
  localparam int EXP_G = GAP;
`else
  localparam int EXP_G = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        iStart = 1'b0;
  logic [31:0] iData = 32'd0;
  logic        iTxDone = 1'b0;
  logic [7:0]  oByte;
  logic        oLoad, oTransmit, oTxReset, oBusy, oDone;
  logic [1:0]  oByteIdx;

  logic        iStart1 = 1'b0;
  logic [7:0]  iData1 = 8'd0;
  logic        iTxDone1 = 1'b1;
  logic [7:0]  oByte1;
  logic        oLoad1, oTransmit1, oTxReset1, oBusy1, oDone1;
  logic [0:0]  oByteIdx1;

  tx_burst_ctrl #(.BYTES(NB), .GAP_CYCLES(GAP)) dut4 (
    .clk(clk), .reset(reset), .iStart(iStart), .iData(iData), .iTxDone(iTxDone),
    .oByte(oByte), .oLoad(oLoad), .oTransmit(oTransmit), .oTxReset(oTxReset),
    .oBusy(oBusy), .oDone(oDone), .oByteIdx(oByteIdx)
  );

  tx_burst_ctrl #(.BYTES(1), .GAP_CYCLES(GAP)) dut1 (
    .clk(clk), .reset(reset), .iStart(iStart1), .iData(iData1), .iTxDone(iTxDone1),
    .oByte(oByte1), .oLoad(oLoad1), .oTransmit(oTransmit1), .oTxReset(oTxReset1),
    .oBusy(oBusy1), .oDone(oDone1), .oByteIdx(oByteIdx1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Observations of one burst, filled by drive_word.
  int          tv [NB];
  int          o_nload, o_ntxr, o_ndone, o_busy;
  int          o_gap [NB];
  logic [7:0]  o_byte [NB];
  logic [7:0]  o_txbyte [NB];
  logic [1:0]  o_idx [NB];
  bit          o_timeout, o_fall_ok;

  // Runs one burst from a negedge: pulses iStart, plays the serializer with
  // per-byte latencies tv[], optionally re-pulses iStart during byte 1.
  task automatic drive_word(input logic [31:0] data, input bit restart);
    int tcnt, gap_run, cur;
    bit prev_done;
    tcnt = 0; gap_run = 0; cur = 0; prev_done = 0;
    o_nload = 0; o_ntxr = 0; o_ndone = 0; o_busy = 0;
    o_timeout = 1; o_fall_ok = 0;
    for (int i = 0; i < NB; i++) begin
      o_gap[i] = -1; o_byte[i] = 8'hxx; o_txbyte[i] = 8'hxx; o_idx[i] = 2'bxx;
    end
    iData = data; iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    iData = $urandom;
    for (int c = 0; c < 3000; c++) begin
      if (oBusy) o_busy++;
      if (oLoad) begin
        if (o_nload < NB) begin
          o_byte[o_nload] = oByte;
          o_idx[o_nload]  = oByteIdx;
          if (o_nload > 0) o_gap[o_nload-1] = gap_run;
        end
        cur = o_nload;
        o_nload++;
        tcnt = 0;
      end
      if (!oTxReset) begin
        o_ntxr++;
        gap_run = 0;
      end
      if (oBusy && !oLoad && !oTransmit && oTxReset && !oDone) gap_run++;
      if (oDone) o_ndone++;
      if (oTransmit) begin
        tcnt++;
        if (cur < NB) o_txbyte[cur] = oByte;
      end
      iTxDone = oTransmit && (cur < NB) && (tcnt == tv[cur % NB]);
      iStart  = restart && oTransmit && (oByteIdx == 2'd1) && (tcnt == 1);
      if (iStart) iData = 32'hFFFF_FFFF;
      if (o_ndone > 0 && !oBusy) begin
        o_timeout = 0;
        o_fall_ok = prev_done;
        break;
      end
      prev_done = oDone;
      @(negedge clk);
    end
    iTxDone = 1'b0;
    iStart  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({oLoad, oTransmit, oTxReset, oBusy, oDone} !== 5'b00100) begin n_err++;
      $display("FAIL reset_strobes: got %b want 00100", {oLoad, oTransmit, oTxReset, oBusy, oDone}); end
    n_cmp++; if ({oByte, oByteIdx} !== 10'd0) begin n_err++;
      $display("FAIL reset_byte_idx: got %h/%0d want 0/0", oByte, oByteIdx); end
    n_cmp++; if ({oLoad1, oTransmit1, oTxReset1, oBusy1, oDone1, oByte1} !== {5'b00100, 8'h00}) begin n_err++;
      $display("FAIL reset_dut1: got %b/%h want 00100/00", {oLoad1, oTransmit1, oTxReset1, oBusy1, oDone1}, oByte1); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Compares one completed burst against the word-level model.
  task automatic check_burst(input string name, input logic [31:0] data);
    int exp_busy;
    exp_busy = (NB - 1) * EXP_G + 1;
    for (int i = 0; i < NB; i++) exp_busy += tv[i] + 2;
    n_cmp++; if (o_timeout !== 1'b0) begin n_err++;
      $display("FAIL %s_timeout: burst did not complete within cycle budget", name); end
    n_cmp++; if (o_nload !== NB || o_ntxr !== NB || o_ndone !== 1) begin n_err++;
      $display("FAIL %s_counts: load/txreset/done got %0d/%0d/%0d want %0d/%0d/1", name, o_nload, o_ntxr, o_ndone, NB, NB); end
    n_cmp++; if (o_busy !== exp_busy) begin n_err++;
      $display("FAIL %s_busy: got %0d cycles want %0d", name, o_busy, exp_busy); end
    n_cmp++; if (o_fall_ok !== 1'b1) begin n_err++;
      $display("FAIL %s_busy_fall: got %0b want 1 (oBusy low right after oDone)", name, o_fall_ok); end
    for (int i = 0; i < NB; i++) begin
      logic [7:0] eb;
      eb = data[8*i +: 8];
      n_cmp++; if (o_byte[i] !== eb || o_txbyte[i] !== eb || o_idx[i] !== 2'(i)) begin n_err++;
        $display("FAIL %s_byte%0d: got load=%h tx=%h idx=%0d want %h/%h/%0d", name, i, o_byte[i], o_txbyte[i], o_idx[i], eb, eb, i); end
      if (i < NB - 1) begin
        n_cmp++; if (o_gap[i] !== EXP_G) begin n_err++;
          $display("FAIL %s_gap%0d: got %0d idle cycles want %0d", name, i, o_gap[i], EXP_G); end
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < NB; i++) tv[i] = 10;
    drive_word(32'hA1B2_C3D4, 1'b0);
    check_burst("basic", 32'hA1B2_C3D4);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      for (int i = 0; i < NB; i++) tv[i] = $urandom_range(1, 6);
      drive_word(d, 1'b0);
      check_burst("random", d);
    end
  endtask

  task automatic test_restart();
    logic [31:0] d;
    d = $urandom;
    for (int i = 0; i < NB; i++) tv[i] = $urandom_range(2, 5);
    drive_word(d, 1'b1);
    check_burst("restart", d);
    repeat (10) begin
      @(negedge clk);
      n_cmp++; if (oBusy !== 1'b0 || oDone !== 1'b0) begin n_err++;
        $display("FAIL restart_idle: got busy=%0b done=%0b want 0/0", oBusy, oDone); end
    end
  endtask

  task automatic test_reset_midflight();
    int tcnt;
    bit hit;
    tcnt = 0; hit = 0;
    iData = 32'h1122_3344; iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (oLoad) tcnt = 0;
      if (oTransmit) tcnt++;
      if (oTransmit && oByteIdx == 2'd2 && tcnt == 2) begin hit = 1; break; end
      iTxDone = oTransmit && (tcnt == 3);
      @(negedge clk);
    end
    iTxDone = 1'b0;
    n_cmp++; if (hit !== 1'b1) begin n_err++;
      $display("FAIL midrst_reach: never reached byte 2 transmit, got 0 want 1"); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({oTransmit, oBusy, oLoad, oTxReset, oDone} !== 5'b00010) begin n_err++;
      $display("FAIL midrst_strobes: got tx/busy/load/txr/done=%b want 00010", {oTransmit, oBusy, oLoad, oTxReset, oDone}); end
    n_cmp++; if (oByte !== 8'h00 || oByteIdx !== 2'd0) begin n_err++;
      $display("FAIL midrst_byte: got %h/%0d want 00/0", oByte, oByteIdx); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NB; i++) tv[i] = 3;
    drive_word(32'h5566_7788, 1'b0);
    check_burst("after_rst", 32'h5566_7788);
  endtask

  task automatic test_idle_txdone();
    iTxDone = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (oTxReset !== 1'b1 || oBusy !== 1'b0) begin n_err++;
        $display("FAIL idle_txdone: got txr=%0b busy=%0b want 1/0", oTxReset, oBusy); end
    end
    iData = 32'hCAFE_F00D; iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    n_cmp++; if (oLoad !== 1'b1 || oByte !== 8'h0D) begin n_err++;
      $display("FAIL load_txdone_load: got load=%0b byte=%h want 1/0d", oLoad, oByte); end
    @(negedge clk);
    iTxDone = 1'b0;
    repeat (3) begin
      n_cmp++; if (oTransmit !== 1'b1 || oTxReset !== 1'b1) begin n_err++;
        $display("FAIL load_txdone_hold: got tx=%0b txr=%0b want 1/1", oTransmit, oTxReset); end
      @(negedge clk);
    end
    for (int c = 0; c < 300; c++) begin
      iTxDone = oTransmit;
      @(negedge clk);
      if (!oBusy) break;
    end
    iTxDone = 1'b0;
    n_cmp++; if (oBusy !== 1'b0) begin n_err++;
      $display("FAIL load_txdone_finish: got busy=%0b want 0", oBusy); end
  endtask

  task automatic test_single();
    logic [5:0] ld, tx, txr, dn, bz;
    logic [7:0] b0;
    ld = '0; tx = '0; txr = '0; dn = '0; bz = '0;
    iData1 = 8'h5A; iStart1 = 1'b1;
    @(negedge clk);
    iStart1 = 1'b0;
    iData1 = $urandom;
    b0 = oByte1;
    for (int c = 0; c < 6; c++) begin
      ld[c] = oLoad1; tx[c] = oTransmit1; txr[c] = ~oTxReset1; dn[c] = oDone1; bz[c] = oBusy1;
      if (c < 5) @(negedge clk);
    end
    n_cmp++; if (ld !== 6'b000001 || tx !== 6'b000010 || txr !== 6'b000100 || dn !== 6'b001000) begin n_err++;
      $display("FAIL single_seq: got load=%b tx=%b txr=%b done=%b want 000001/000010/000100/001000", ld, tx, txr, dn); end
    n_cmp++; if (bz !== 6'b001111) begin n_err++;
      $display("FAIL single_busy: got %b want 001111", bz); end
    n_cmp++; if (b0 !== 8'h5A || oByteIdx1 !== 1'b0) begin n_err++;
      $display("FAIL single_byte: got %h/%0d want 5a/0", b0, oByteIdx1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_restart();
    test_reset_midflight();
    test_idle_txdone();
    test_single();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_burst_ctrl.md
# tx_burst_ctrl

Parametrised transmit sequencer between the register/command layer and the UART byte serializer. It accepts a multi-byte word with a single start request and drives the serializer's load/transmit/reset handshake once per byte, least-significant byte first. It reports busy/done status to the requester. This block supersedes single-byte transmit control for all multi-byte UART traffic.

## Interface
- BYTES, 4: bytes per word, 1..16; IW = max(1, $clog2(BYTES))
- GAP_CYCLES, 16: idle cycles inserted between consecutive bytes, 0..65535; 16-bit counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- iStart  in  1  request to send iData; sampled only in IDLE
- iData  in  8*BYTES  word to send, captured on accepted iStart
- iTxDone  in  1  serializer byte-complete pulse; sampled only in TRANSMIT
- oByte  out  8  byte presented to serializer
- oLoad  out  1  serializer load strobe, one cycle per byte
- oTransmit  out  1  serializer enable, held high for the whole byte
- oTxReset  out  1  serializer reset, active-low, one-cycle pulse after each byte
- oBusy  out  1  high in every state except IDLE
- oDone  out  1  one-cycle pulse after the last byte completes
- oByteIdx  out  IW  index of the byte currently in flight

## Operation
- States: IDLE, LOAD, TRANSMIT, TXRESET, GAP, DONE; 3-bit encoding, unused codes go to IDLE.
- IDLE:
  - On iStart=1, capture iData into the shadow register, clear idx to 0, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: oLoad=1 for one cycle, then go to TRANSMIT.
- TRANSMIT: oTransmit=1. On iTxDone=1 go to TXRESET; otherwise stay.
- TXRESET: oTxReset=0 for one cycle.
  - If idx==BYTES-1, go to DONE.
  - Otherwise increment idx and go to GAP, or straight to LOAD (see Configuration).
- GAP: load the counter with GAP_CYCLES-1 on entry and decrement it. When the counter reaches 0, go to LOAD.
- DONE: oDone=1 for one cycle, then go to IDLE.
- oByte = shadow[8*idx +: 8], driven from registered idx and shadow; it is stable from LOAD through TXRESET.
- oByteIdx = idx.
- Outputs are Moore-decoded from the state register only.
- Default values outside the listed states: oLoad=0, oTransmit=0, oTxReset=1, oDone=0.
- iStart outside IDLE is ignored. No queueing and no abort.
- iData changes after capture have no effect on the word in flight.
- iTxDone outside TRANSMIT is ignored.
- BYTES=1: the idx width is 1, idx stays 0, and GAP is never entered.
- Reset asserted at any time, including mid-byte:
  - Immediately: state=IDLE, shadow=0, idx=0, gap counter=0.
  - Output reset values: oByte=0, oLoad=0, oTransmit=0, oTxReset=1, oBusy=0, oDone=0, oByteIdx=0.

## Timing
- iStart=1 sampled at edge k:
  - oLoad=1 and oBusy=1 during cycle k+1.
  - oTransmit=1 from cycle k+2.
- Per byte: 1 (LOAD) + T (TRANSMIT, where iTxDone arrives on the T-th TRANSMIT cycle) + 1 (TXRESET).
- Gap: GAP_CYCLES cycles between TXRESET and the next LOAD when enabled and GAP_CYCLES>0.
- Total busy cycles: BYTES*(T+2) + (BYTES-1)*G + 1 (DONE). G = GAP_CYCLES when the gap feature is active, else 0.
- oDone rises the cycle after the last TXRESET. oBusy falls the following cycle.
- Earliest next accepted iStart: the first IDLE cycle after DONE.
- iTxDone coincident with the first TRANSMIT cycle counts (T=1).

## Configuration
- TX_BURST_GAP_EN defined:
  - GAP state and counter are present.
  - After each non-final byte, TXRESET goes to GAP when GAP_CYCLES>0, or directly to LOAD when GAP_CYCLES=0.
- TX_BURST_GAP_EN undefined:
  - GAP state and counter are not synthesized.
  - TXRESET goes directly to LOAD for non-final bytes.
  - GAP_CYCLES is ignored.

## Test plan
- BYTES=4, gap disabled, iData=0xA1B2C3D4, iStart pulse, serializer model returns iTxDone after 10 cycles:
  - oByte sequence D4, C3, B2, A1 with oByteIdx 0..3.
  - Exactly 4 oLoad and 4 oTxReset pulses.
  - oDone one cycle, 4*12+1=49 busy cycles.
- TX_BURST_GAP_EN, GAP_CYCLES=5, same stimulus:
  - 5 idle cycles (all strobes inactive) between each TXRESET and the next LOAD.
  - 64 busy cycles.
- iStart re-pulsed with iData=0xFFFFFFFF while byte 1 is transmitting:
  - Ignored; original bytes are sent.
  - Only one oDone.
- Reset driven low mid-TRANSMIT of byte 2:
  - Same cycle: oTransmit=0, oBusy=0, oByte=0, oByteIdx=0.
  - After release, a new iStart sends from byte 0.
- BYTES=1, iData=0x5A, iTxDone held high constantly:
  - LOAD, TRANSMIT(1), TXRESET, DONE, IDLE.
  - oByte=0x5A, 4 busy cycles.
- iTxDone pulses while in IDLE and LOAD: no state change, no extra oTxReset.
